// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one or two stop bits; UART_TX_HOLD_BUF_EN adds a one-word holding buffer.
// Latency: start bit is on TX_OUT the cycle after the accepting edge; every bit lasts CLKS_PER_BIT cycles.
// Backpressure: TX_READY is low while a frame is in flight, or only while the holding buffer is full when UART_TX_HOLD_BUF_EN is defined.
module uart_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  TX_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] frame_dat;     // shifts right as data bits go out
    logic                  frame_par_en;
    logic                  frame_par;     // parity bit value, computed once at load
    logic                  frame_stop2;
    logic                  stop_second;   // currently in the second stop bit

    logic                  bit_wrap;
    logic                  last_stop;
    logic                  accept;
    logic                  do_load;
    logic                  nxt_vld;
    logic [DATA_WIDTH-1:0] nxt_dat;
    logic                  nxt_par_en;
    logic                  nxt_par_typ;
    logic                  nxt_stop2;

    assign bit_wrap  = (bit_cnt == CNT_LAST);
    assign last_stop = (state == STOP) && bit_wrap && (stop_second || !frame_stop2);
    assign accept    = DATA_VALID && TX_READY;
    // A new frame may only begin from idle or exactly at the final stop-bit wrap.
    assign do_load   = nxt_vld && ((state == IDLE) || last_stop);

`ifdef UART_TX_HOLD_BUF_EN
    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_dat;
    logic                  buf_par_en;
    logic                  buf_par_typ;
    logic                  buf_stop2;

    assign TX_READY = !buf_full;

    // Next frame comes from the buffer when it holds a word, otherwise straight from the inputs.
    always_comb begin
        if (buf_full) begin
            nxt_vld     = 1'b1;
            nxt_dat     = buf_dat;
            nxt_par_en  = buf_par_en;
            nxt_par_typ = buf_par_typ;
            nxt_stop2   = buf_stop2;
        end else begin
            nxt_vld     = accept;
            nxt_dat     = P_DATA;
            nxt_par_en  = PAR_EN;
            nxt_par_typ = PAR_TYP;
            nxt_stop2   = STOP2;
        end
    end

    // Park a word accepted mid-frame; it is released into the frame registers at the final stop wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            buf_full    <= 1'b0;
            buf_dat     <= '0;
            buf_par_en  <= 1'b0;
            buf_par_typ <= 1'b0;
            buf_stop2   <= 1'b0;
        end else if (accept && (state != IDLE) && !last_stop) begin
            buf_full    <= 1'b1;
            buf_dat     <= P_DATA;
            buf_par_en  <= PAR_EN;
            buf_par_typ <= PAR_TYP;
            buf_stop2   <= STOP2;
        end else if (buf_full && last_stop) begin
            buf_full    <= 1'b0;
        end
    end
`else
    assign TX_READY    = (state == IDLE);
    assign nxt_vld     = accept;
    assign nxt_dat     = P_DATA;
    assign nxt_par_en  = PAR_EN;
    assign nxt_par_typ = PAR_TYP;
    assign nxt_stop2   = STOP2;
`endif

    // Frame state machine: bit timing, bit sequencing and the registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            frame_dat    <= '0;
            frame_par_en <= 1'b0;
            frame_par    <= 1'b0;
            frame_stop2  <= 1'b0;
            stop_second  <= 1'b0;
            TX_OUT       <= 1'b1;
            BUSY         <= 1'b0;
        end else if (do_load) begin
            state        <= START;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            stop_second  <= 1'b0;
            frame_dat    <= nxt_dat;
            frame_par_en <= nxt_par_en;
            frame_par    <= (^nxt_dat) ^ nxt_par_typ;
            frame_stop2  <= nxt_stop2;
            TX_OUT       <= 1'b0;
            BUSY         <= 1'b1;
        end else if (state != IDLE) begin
            bit_cnt <= bit_wrap ? '0 : bit_cnt + CNT_W'(1);
            if (bit_wrap) begin
                case (state)
                    START: begin
                        state  <= DATA;
                        TX_OUT <= frame_dat[0];
                    end
                    DATA: begin
                        if (bit_idx == IDX_LAST) begin
                            if (frame_par_en) begin
                                state  <= PARITY;
                                TX_OUT <= frame_par;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            frame_dat <= frame_dat >> 1;
                            TX_OUT    <= frame_dat[1];
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state  <= IDLE;
                            BUSY   <= 1'b0;
                            TX_OUT <= 1'b1;
                        end else begin
                            stop_second <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        BUSY   <= 1'b0;
                        TX_OUT <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
